// File: rtl/iso16_seal_responder.sv
// iso16_seal_responder: fixed-latency 256-bit seal mixer at the delivery-loop seal boundary.
// Optional consistency reject guarded by ISO16_SEAL_CONSISTENCY_EN.
module iso16_seal_responder #(
   parameter int WARP_WIDTH  = 16,
   parameter int ERROR_WIDTH = 32,
   parameter int SEAL_ROUNDS = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   seal_start,
   input  logic [15:0]            vector_id,
   input  logic [WARP_WIDTH-1:0]  warp_sum_x,
   input  logic [WARP_WIDTH-1:0]  warp_sum_y,
   input  logic [WARP_WIDTH-1:0]  warp_sum_z,
   input  logic [ERROR_WIDTH-1:0] error_sum,
   input  logic                   symmetry_ok,
   input  logic                   error_ok,
   input  logic                   true_delivery,
   input  logic                   clear_overrun,
   output logic                   busy,
   output logic                   seal_ready,
   output logic [255:0]           seal,
   output logic                   overrun,
   output logic                   seal_reject
);
   typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;
   state_t state_q, state_d;
   logic [7:0] r_q, r_d;
   logic [255:0] s_q, s_d, seal_q, seal_d;
   logic rej_q, rej_d, ready_q, ready_d, busy_q, busy_d, ovr_q, ovr_d, srej_q, srej_d;
   logic [127:0] h;
   logic [63:0] a, b, c, d, sum, mixd;
   logic rej_hit;
`ifdef ISO16_SEAL_CONSISTENCY_EN
   assign rej_hit = true_delivery != (symmetry_ok & error_ok);
`else
   assign rej_hit = 1'b0;
`endif
   assign h = {vector_id, 16'(warp_sum_x), 16'(warp_sum_y), 16'(warp_sum_z), 32'(error_sum),
               29'd0, symmetry_ok, error_ok, true_delivery};
   assign {a, b, c, d} = s_q;
   assign sum = b + c;
   assign mixd = a ^ {sum[56:0], sum[63:57]} ^ {56'd0, r_q};
   always_comb begin
      state_d = state_q;
      r_d = r_q;
      s_d = s_q;
      rej_d = rej_q;
      seal_d = seal_q;
      ready_d = 1'b0;
      srej_d = 1'b0;
      ovr_d = ovr_q & ~clear_overrun;
      if (state_q == DONE) begin
         seal_d = s_q;
         ready_d = 1'b1;
         srej_d = rej_q;
      end
      if (state_q == MIX) begin
         s_d = {b, c, d, mixd};
         r_d = r_q + 8'd1;
         state_d = (r_q == 8'(SEAL_ROUNDS - 1)) ? DONE : MIX;
         ovr_d = seal_start | ovr_d;
      end else if (seal_start) begin
         // A rejected request carries an all-zero state so DONE publishes a zero seal.
         s_d = rej_hit ? 256'd0 : {h, ~h};
         r_d = 8'd0;
         rej_d = rej_hit;
         state_d = rej_hit ? DONE : MIX;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
      busy_d = state_d == MIX;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         r_q <= 8'd0;
         s_q <= 256'd0;
         seal_q <= 256'd0;
         rej_q <= 1'b0;
         ready_q <= 1'b0;
         busy_q <= 1'b0;
         ovr_q <= 1'b0;
         srej_q <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q <= r_d;
         s_q <= s_d;
         seal_q <= seal_d;
         rej_q <= rej_d;
         ready_q <= ready_d;
         busy_q <= busy_d;
         ovr_q <= ovr_d;
         srej_q <= srej_d;
      end
   end
   assign busy = busy_q;
   assign seal_ready = ready_q;
   assign seal = seal_q;
   assign overrun = ovr_q;
   assign seal_reject = srej_q;
endmodule

// File: tb/tb_iso16_seal_responder.sv
// tb_iso16_seal_responder: randomized and directed checks against a transaction-level seal model.
module tb_iso16_seal_responder;
   localparam int SR = 8;
   logic clk = 1'b0, rst_n = 1'b0, seal_start = 1'b0, clear_overrun = 1'b0;
   logic [15:0] vector_id = 16'd0, wx = 16'd0, wy = 16'd0, wz = 16'd0;
   logic [31:0] err = 32'd0;
   logic sym = 1'b0, eok = 1'b0, td = 1'b0;
   logic busy, seal_ready, overrun, seal_reject;
   logic [255:0] seal;
   always #5 clk = ~clk;
   iso16_seal_responder #(.WARP_WIDTH(16), .ERROR_WIDTH(32), .SEAL_ROUNDS(SR)) dut (
      .clk(clk), .rst_n(rst_n), .seal_start(seal_start), .vector_id(vector_id),
      .warp_sum_x(wx), .warp_sum_y(wy), .warp_sum_z(wz), .error_sum(err),
      .symmetry_ok(sym), .error_ok(eok), .true_delivery(td), .clear_overrun(clear_overrun),
      .busy(busy), .seal_ready(seal_ready), .seal(seal), .overrun(overrun), .seal_reject(seal_reject));
   int checks = 0, failures = 0;
   int n = 0, mix_k = -1000;
   int due_q[$];
   logic [255:0] sq_q[$];
   bit rq_q[$];
   logic e_busy = 1'b0, e_ready = 1'b0, e_ovr = 1'b0, e_rej = 1'b0;
   logic [255:0] e_seal = 256'd0, first;
   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at edge %0d: got %h expected %h", tag, n, got, exp);
      end
   endtask
   function automatic logic [255:0] mix(input logic [127:0] h);
      logic [63:0] l0, l1, l2, l3, s, nl;
      l0 = h[127:64]; l1 = h[63:0]; l2 = ~h[127:64]; l3 = ~h[63:0];
      for (int r = 0; r < SR; r++) begin
         s = l1 + l2;
         nl = l0 ^ ((s << 7) | (s >> 57)) ^ 64'(r);
         l0 = l1; l1 = l2; l2 = l3; l3 = nl;
      end
      return {l0, l1, l2, l3};
   endfunction
   task automatic step();
      logic busy_before;
      logic [127:0] h;
      bit rej;
      @(posedge clk);
      n++;
      busy_before = n >= mix_k + 1 && n <= mix_k + SR;
      if (!rst_n) begin
         due_q.delete(); sq_q.delete(); rq_q.delete();
         mix_k = -1000;
         e_seal = 256'd0; e_ovr = 1'b0; e_ready = 1'b0; e_rej = 1'b0; e_busy = 1'b0;
      end else begin
         e_ready = 1'b0;
         e_rej = 1'b0;
         if (due_q.size() > 0 && due_q[0] == n) begin
            e_ready = 1'b1;
            e_seal = sq_q.pop_front();
            e_rej = rq_q.pop_front();
            void'(due_q.pop_front());
         end
         e_ovr = (busy_before && seal_start) ? 1'b1 : clear_overrun ? 1'b0 : e_ovr;
         if (seal_start && !busy_before) begin
            h = {vector_id, wx, wy, wz, err, 29'd0, sym, eok, td};
`ifdef ISO16_SEAL_CONSISTENCY_EN
            rej = td != (sym & eok);
`else
            rej = 1'b0;
`endif
            if (rej) begin
               due_q.push_back(n + 2); sq_q.push_back(256'd0); rq_q.push_back(1'b1);
            end else begin
               due_q.push_back(n + SR + 1); sq_q.push_back(mix(h)); rq_q.push_back(1'b0);
               mix_k = n;
            end
         end
         e_busy = n >= mix_k && n <= mix_k + SR - 1;
      end
      @(negedge clk);
      chk("busy", 256'(busy), 256'(e_busy));
      chk("seal_ready", 256'(seal_ready), 256'(e_ready));
      chk("seal", seal, e_seal);
      chk("overrun", 256'(overrun), 256'(e_ovr));
      chk("seal_reject", 256'(seal_reject), 256'(e_rej));
   endtask
   task automatic fields(input logic [15:0] v);
      vector_id = v; wx = 16'h0010; wy = 16'h0020; wz = 16'h0030; err = 32'h5;
      sym = 1'b1; eok = 1'b1; td = 1'b1;
   endtask
   initial begin
      @(negedge clk);
      repeat (2) step();
      rst_n = 1'b1;
      fields(16'h0001);
      seal_start = 1'b1; step(); seal_start = 1'b0;
      repeat (SR + 2) step();
      seal_start = 1'b1; step(); seal_start = 1'b0;
      repeat (3) step();
      seal_start = 1'b1; step(); seal_start = 1'b0;
      repeat (SR) step();
      clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
      seal_start = 1'b1; step(); seal_start = 1'b0;
      repeat (2) step();
      seal_start = 1'b1; clear_overrun = 1'b1; step(); seal_start = 1'b0; clear_overrun = 1'b0;
      repeat (SR) step();
      seal_start = 1'b1; step(); seal_start = 1'b0;
      repeat (SR) step();
      fields(16'hBEEF);
      seal_start = 1'b1; step(); seal_start = 1'b0;
      first = seal;
      repeat (SR + 1) step();
      chk("digest_differs", 256'(seal != first), 256'(1));
      repeat (3) step();
      fields(16'h0001);
      seal_start = 1'b1; step(); seal_start = 1'b0;
      repeat (4) step();
      rst_n = 1'b0; step(); rst_n = 1'b1;
      seal_start = 1'b1; step(); seal_start = 1'b0;
      repeat (SR + 2) step();
      eok = 1'b0;
      seal_start = 1'b1; step(); seal_start = 1'b0;
      repeat (SR + 2) step();
      repeat (400) begin
         seal_start = $urandom_range(0, 5) == 0;
         clear_overrun = $urandom_range(0, 7) == 0;
         rst_n = $urandom_range(0, 149) != 0;
         vector_id = 16'($urandom); wx = 16'($urandom); wy = 16'($urandom); wz = 16'($urandom);
         err = $urandom;
         sym = 1'($urandom); eok = 1'($urandom); td = 1'($urandom);
         step();
      end
      rst_n = 1'b1; seal_start = 1'b0; clear_overrun = 1'b0;
      repeat (SR + 3) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
